// File: rtl/regfile_rr_arbiter_if.sv
// Requester and register-file signal bundle for the two-port round-robin register file arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface regfile_rr_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    // Requester side
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr_a0;
    logic [ADDR_W-1:0] addr_a1;
    logic [ADDR_W-1:0] addr_b0;
    logic [ADDR_W-1:0] addr_b1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rd_src;
    logic [DATA_W-1:0] rd_dest;
    logic              busy;

    // Register file side
    logic [ADDR_W-1:0] rf_addr_a;
    logic [ADDR_W-1:0] rf_addr_b;
    logic              rf_wr;
    logic [DATA_W-1:0] rf_data_in;
    logic [DATA_W-1:0] rf_src;
    logic [DATA_W-1:0] rf_dest;

    modport slave (
        input  req0, req1, we0, we1, addr_a0, addr_a1, addr_b0, addr_b1, wdata0, wdata1,
        input  rf_src, rf_dest,
        output ack0, ack1, err0, err1, rd_src, rd_dest, busy,
        output rf_addr_a, rf_addr_b, rf_wr, rf_data_in
    );

    modport master (
        output req0, req1, we0, we1, addr_a0, addr_a1, addr_b0, addr_b1, wdata0, wdata1,
        output rf_src, rf_dest,
        input  ack0, ack1, err0, err1, rd_src, rd_dest, busy,
        input  rf_addr_a, rf_addr_b, rf_wr, rf_data_in
    );
endinterface

// File: rtl/regfile_rr_arbiter.sv
// Round-robin arbiter sharing one register file between two req/ack requesters.
// Each access runs IDLE -> ISSUE -> CAPT -> ACK; out-of-range addresses take IDLE -> ERR.
module regfile_rr_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    regfile_rr_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_CAPT  = 3'd2,
        S_ACK   = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    localparam logic [ADDR_W:0] REG_LIMIT = NUM_REGS[ADDR_W:0];

    state_e            state_q,   state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_a_q,  addr_a_d;
    logic [ADDR_W-1:0] addr_b_q,  addr_b_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] rd_src_q,  rd_src_d;
    logic [DATA_W-1:0] rd_dest_q, rd_dest_d;

    // Candidate grantee and its request fields, valid whenever a request is pending
    logic              sel_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr_a;
    logic [ADDR_W-1:0] sel_addr_b;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} >= REG_LIMIT;
    endfunction

    // Port 1 wins when alone, or when both ask and port 0 was served last.
    assign sel_port   = bus.req1 & (~bus.req0 | ~last_gnt_q);
    assign sel_we     = sel_port ? bus.we1     : bus.we0;
    assign sel_addr_a = sel_port ? bus.addr_a1 : bus.addr_a0;
    assign sel_addr_b = sel_port ? bus.addr_b1 : bus.addr_b0;
    assign sel_wdata  = sel_port ? bus.wdata1  : bus.wdata0;
    assign sel_bad    = out_of_range(sel_addr_a) | out_of_range(sel_addr_b);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latches).
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        wdata_d    = wdata_q;
        rd_src_d   = rd_src_q;
        rd_dest_d  = rd_dest_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    last_gnt_d = sel_port;
                    we_d       = sel_we;
                    addr_a_d   = sel_addr_a;
                    addr_b_d   = sel_addr_b;
                    wdata_d    = sel_wdata;
                    state_d    = sel_bad ? S_ERR : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_CAPT;
            S_CAPT: begin
                // Register file read data settles one cycle after ISSUE; it holds the pre-write contents.
                rd_src_d  = bus.rf_src;
                rd_dest_d = bus.rf_dest;
                state_d   = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            wdata_q    <= '0;
            rd_src_q   <= '0;
            rd_dest_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples its pre-edge _d value regardless of statement order.
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            wdata_q    <= wdata_d;
            rd_src_q   <= rd_src_d;
            rd_dest_q  <= rd_dest_d;
        end
    end

    // Write strobe is a pure state decode, so an asynchronous reset kills a pending write at once.
    assign bus.rf_wr      = (state_q == S_ISSUE) & we_q;
    assign bus.rf_addr_a  = addr_a_q;
    assign bus.rf_addr_b  = addr_b_q;
    assign bus.rf_data_in = wdata_q;

    assign bus.ack0    = (state_q == S_ACK) & ~last_gnt_q;
    assign bus.ack1    = (state_q == S_ACK) &  last_gnt_q;
    assign bus.err0    = (state_q == S_ERR) & ~last_gnt_q;
    assign bus.err1    = (state_q == S_ERR) &  last_gnt_q;
    assign bus.rd_src  = rd_src_q;
    assign bus.rd_dest = rd_dest_q;
    assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// Scoreboard bench for regfile_rr_arbiter: a transaction-level model predicts grant order,
// response kind, read data and response cycle; a negedge monitor compares DUT responses.
module tb_regfile_rr_arbiter;

    typedef struct {
        bit          we;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] wd;
    } txn_t;

    typedef struct {
        bit          port;
        bit          err;
        logic [15:0] src;
        logic [15:0] dest;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    regfile_rr_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_rr_arbiter #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(8)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file environment: registered read, read-before-write, not reset.
    logic [15:0] rf_mem [8] = '{default: 16'h0};
    always @(posedge clk) begin
        bus.rf_src  <= (bus.rf_addr_a < 4'd8) ? rf_mem[bus.rf_addr_a[2:0]] : 16'h0;
        bus.rf_dest <= (bus.rf_addr_b < 4'd8) ? rf_mem[bus.rf_addr_b[2:0]] : 16'h0;
        if (bus.rf_wr && bus.rf_addr_b < 4'd8) rf_mem[bus.rf_addr_b[2:0]] <= bus.rf_data_in;
    end

    int          tests = 0;
    int          fails = 0;
    bit          abort = 0;
    bit          mon_en = 0;
    int          rf_wr_cycles = 0;
    int          model_writes = 0;
    bit          model_last = 1'b1;
    logic [15:0] ref_mem [8] = '{default: 16'h0};
    exp_t        exp_q [$];
    txn_t        pq0 [$];
    txn_t        pq1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per ack/err pulse.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bus.rf_wr) begin
                rf_wr_cycles++;
                check("rf_wr_addr_in_range", {31'b0, bus.rf_addr_b < 4'd8}, 32'd1);
            end
            if (bus.ack0 | bus.ack1 | bus.err0 | bus.err1) begin
                check("resp_onehot", 32'(bus.ack0) + 32'(bus.ack1) + 32'(bus.err0) + 32'(bus.err1), 32'd1);
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_port", {31'b0, bus.ack1 | bus.err1}, {31'b0, e.port});
                    check("resp_is_err", {31'b0, bus.err0 | bus.err1}, {31'b0, e.err});
                    check("resp_cycle", cyc, e.cyc);
                    if (!e.err) begin
                        check("rd_src", {16'h0, bus.rd_src}, {16'h0, e.src});
                        check("rd_dest", {16'h0, bus.rd_dest}, {16'h0, e.dest});
                    end
                end
            end
        end
    end

    task automatic drive_port(input int p, input txn_t t);
        if (p == 0) begin
            bus.we0 = t.we; bus.addr_a0 = t.a; bus.addr_b0 = t.b; bus.wdata0 = t.wd; bus.req0 = 1'b1;
        end else begin
            bus.we1 = t.we; bus.addr_a1 = t.a; bus.addr_b1 = t.b; bus.wdata1 = t.wd; bus.req1 = 1'b1;
        end
    endtask

    task automatic drop_req(input int p);
        if (p == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
    endtask

    // Access semantics at transaction level: error if either address is beyond 8 registers,
    // otherwise old contents come back and the write lands afterwards.
    task automatic predict(input int p, input txn_t t, input int g);
        exp_t e;
        e.port = p[0];
        e.err  = (t.a >= 4'd8) || (t.b >= 4'd8);
        e.src  = 16'h0;
        e.dest = 16'h0;
        if (e.err) begin
            e.cyc = g;
        end else begin
            e.src  = ref_mem[t.a[2:0]];
            e.dest = ref_mem[t.b[2:0]];
            e.cyc  = g + 2;
            if (t.we) begin
                ref_mem[t.b[2:0]] = t.wd;
                model_writes++;
            end
        end
        exp_q.push_back(e);
    endtask

    // Issues everything queued in pq0/pq1, one outstanding request per port, until both drain.
    task automatic run_engine();
        bit   pend [2];
        txn_t cur [2];
        bit   from_idle;
        bit   got;
        int   w;
        pend[0] = 0;
        pend[1] = 0;
        from_idle = 1;
        @(negedge clk);
        check("idle_busy", {31'b0, bus.busy}, 32'd0);
        forever begin
            if (!pend[0] && pq0.size() > 0) begin cur[0] = pq0.pop_front(); drive_port(0, cur[0]); pend[0] = 1; end
            if (!pend[1] && pq1.size() > 0) begin cur[1] = pq1.pop_front(); drive_port(1, cur[1]); pend[1] = 1; end
            if (!pend[0] && !pend[1]) break;
            if (pend[0] && pend[1]) w = model_last ? 0 : 1;
            else                    w = pend[1] ? 1 : 0;
            model_last = w[0];
            // Idle arbiter grants at the next edge; after a response it passes through IDLE first.
            predict(w, cur[w], cyc + (from_idle ? 1 : 2));
            from_idle = 0;
            got = 0;
            for (int k = 0; k < 16 && !got; k++) begin
                @(negedge clk);
                if (k == 1 && $urandom_range(0, 3) == 0) drop_req(w);
                got = bus.ack0 | bus.ack1 | bus.err0 | bus.err1;
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL response_timeout: got no ack/err expected one for port %0d", w);
                abort = 1;
                return;
            end
            drop_req(w);
            pend[w] = 0;
        end
    endtask

    function automatic txn_t mk(input bit we, input logic [3:0] a, input logic [3:0] b, input logic [15:0] wd);
        txn_t t;
        t.we = we; t.a = a; t.b = b; t.wd = wd;
        return t;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr_a0 = 0; bus.addr_a1 = 0; bus.addr_b0 = 0; bus.addr_b1 = 0;
        bus.wdata0 = 0; bus.wdata1 = 0;
        rst_n = 1'b0;
        #1;
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_rf_wr", {31'b0, bus.rf_wr}, 32'd0);
        check("reset_rd_src", {16'h0, bus.rd_src}, 32'd0);
        check("reset_rf_addr_b", {28'h0, bus.rf_addr_b}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: reset in the middle of a write access
        @(negedge clk);
        drive_port(0, mk(1, 4'd0, 4'd2, 16'hFFFF));
        @(negedge clk);
        check("t1_issue_rf_wr", {31'b0, bus.rf_wr}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_busy", {31'b0, bus.busy}, 32'd0);
        check("t1_ack0", {31'b0, bus.ack0}, 32'd0);
        check("t1_rf_wr", {31'b0, bus.rf_wr}, 32'd0);
        drop_req(0);
        model_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_reg_kept", {16'h0, rf_mem[2]}, 32'd0);
        mon_en = 1;

        // T2: write then read back; also confirm register 2 was left alone
        pq0.push_back(mk(1, 4'd0, 4'd3, 16'hBEEF));
        pq0.push_back(mk(0, 4'd3, 4'd2, 16'h0000));
        run_engine();

        // T5: same source and destination on a write
        if (!abort) begin
            pq1.push_back(mk(1, 4'd5, 4'd5, 16'h1234));
            pq1.push_back(mk(0, 4'd5, 4'd5, 16'h0000));
            run_engine();
        end

        // T4: out-of-range destination
        if (!abort) begin
            pq1.push_back(mk(1, 4'd1, 4'd9, 16'hDEAD));
            run_engine();
        end

        // T3: both ports contend continuously
        if (!abort) begin
            for (int i = 0; i < 4; i++) begin
                pq0.push_back(mk(1, 4'(i), 4'(i + 1), 16'(16'hA000 + i)));
                pq1.push_back(mk(1, 4'(i + 2), 4'(i + 4), 16'(16'hB000 + i)));
            end
            run_engine();
        end

        // T6: port 1 alone, back-to-back
        if (!abort) begin
            for (int i = 0; i < 4; i++) pq1.push_back(mk(i[0], 4'(i), 4'(7 - i), 16'(16'hC000 + i)));
            run_engine();
        end

        // Random mix, including out-of-range addresses and early req drops
        for (int r = 0; r < 40 && !abort; r++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            for (int i = 0; i < n0; i++)
                pq0.push_back(mk($urandom_range(0, 1) == 1, 4'($urandom_range(0, 9)),
                                 4'($urandom_range(0, 9)), 16'($urandom)));
            for (int i = 0; i < n1; i++)
                pq1.push_back(mk($urandom_range(0, 1) == 1, 4'($urandom_range(0, 9)),
                                 4'($urandom_range(0, 9)), 16'($urandom)));
            run_engine();
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("rf_wr_cycle_count", rf_wr_cycles, model_writes);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
